// File: rtl/alu_seq_muldiv.sv
// Sequential execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU.
// MUL/DIVU/REMU and their iteration hardware exist only when ALU_MULDIV_EN is defined.
module alu_seq_muldiv #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] load_res;
    logic             go_multi;

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             is_mul, is_div, b_zero, is_rem, last_iter, div_ge;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opx, opy, acc;
    logic [WIDTH-1:0] mul_sum, div_rem, div_quo, fin_res;
    logic [WIDTH:0]   div_shift, div_diff;

    assign is_mul    = (aluop == 4'b1000);
    assign is_div    = (aluop == 4'b1001) || (aluop == 4'b1010);
    assign b_zero    = (b == '0);
    assign go_multi  = is_mul || (is_div && !b_zero);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Multiply: opx is the left-shifting multiplicand, opy the right-shifting multiplier.
    assign mul_sum   = acc + (opy[0] ? opx : '0);

    // Restoring divide: acc is the partial remainder, opx shifts dividend out and quotient in.
    assign div_shift = {acc, opx[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opy};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {opx[WIDTH-2:0], div_ge};
    assign fin_res   = (state == MUL) ? mul_sum : (is_rem ? div_rem : div_quo);
`else
    assign go_multi  = 1'b0;
`endif

    always_comb begin
        single_res = '0;
        case (aluop)
            4'b0000: single_res = a & b;
            4'b0001: single_res = a | b;
            4'b0010: single_res = a + b;
            4'b0110: single_res = a - b;
            4'b1100: single_res = ~(a | b);
            4'b0100: single_res = a << b[SH_W-1:0];
            4'b0101: single_res = a >> b[SH_W-1:0];
            4'b0111: single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        load_res = single_res;
`ifdef ALU_MULDIV_EN
        if (is_div && b_zero) begin
            load_res = (aluop == 4'b1001) ? '1 : a;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (is_mul) begin
                        state_next = MUL;
                    end else if (go_multi) begin
                        state_next = DIV;
                    end else begin
                        state_next = DONE;
                    end
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            MUL:     if (last_iter) state_next = DONE;
            DIV:     if (last_iter) state_next = DONE;
`endif
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Multi-cycle ops leave result untouched until their last iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
            zero   <= 1'b0;
        end else if ((state == IDLE) && in_valid && !go_multi) begin
            result <= load_res;
            zero   <= (load_res == '0);
        end
`ifdef ALU_MULDIV_EN
        else if (((state == MUL) || (state == DIV)) && last_iter) begin
            result <= fin_res;
            zero   <= (fin_res == '0);
        end
`endif
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            opx    <= '0;
            opy    <= '0;
            acc    <= '0;
            is_rem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= '0;
                        opx    <= a;
                        opy    <= b;
                        acc    <= '0;
                        is_rem <= (aluop == 4'b1010);
                    end
                end
                MUL: begin
                    acc <= mul_sum;
                    opx <= opx << 1;
                    opy <= opy >> 1;
                    cnt <= cnt + CNT_W'(1);
                end
                DIV: begin
                    acc <= div_rem;
                    opx <= div_quo;
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule
